// File: rtl/aib_avmm_cmd_engine.sv
// Queued multi-channel Avalon-MM configuration master: FIFO of commands, one bus transaction at a time,
// one response per command. Define AIB_AVMM_CMD_TIMEOUT_EN to build the per-phase timeout (err=1).
module aib_avmm_cmd_engine #(
  parameter int NUM_CHNL   = 24,
  parameter int CHNL_W     = 6,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          i_cfg_avmm_clk,
  input  logic                          i_cfg_avmm_rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_write,
  input  logic [CHNL_W-1:0]             i_cmd_chnl,
  input  logic [ADDR_W-1:0]             i_cmd_addr,
  input  logic [DATA_W/8-1:0]           i_cmd_byte_en,
  input  logic [DATA_W-1:0]             i_cmd_wdata,
  output logic [CHNL_W-1:0]             o_channel_id,
  output logic                          o_cfg_avmm_write,
  output logic                          o_cfg_avmm_read,
  output logic [ADDR_W-1:0]             o_cfg_avmm_addr,
  output logic [DATA_W/8-1:0]           o_cfg_avmm_byte_en,
  output logic [DATA_W-1:0]             o_cfg_avmm_wdata,
  input  logic                          i_cfg_avmm_waitreq,
  input  logic                          i_cfg_avmm_rdatavld,
  input  logic [DATA_W-1:0]             i_cfg_avmm_rdata,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic [CHNL_W-1:0]             o_rsp_chnl,
  output logic [1:0]                    o_rsp_err,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (NUM_CHNL > 2**CHNL_W || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("aib_avmm_cmd_engine: illegal parameter set");
  end

  typedef struct packed {
    logic                write;
    logic [CHNL_W-1:0]   chnl;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RSP} state_t;

  state_t           state;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push, pop, bad_chnl, to_hit;

  assign o_cmd_ready = (cnt != CNT_W'(FIFO_DEPTH));
  assign o_fifo_cnt  = cnt;
  assign o_busy      = (state != IDLE) || (cnt != '0);
  assign push        = i_cmd_valid & o_cmd_ready;
  assign pop         = (state == IDLE) && (cnt != '0);
  assign head        = mem[rd_ptr];
  assign bad_chnl    = (32'(head.chnl) >= 32'(NUM_CHNL));

  always_ff @(posedge i_cfg_avmm_clk)
    if (push) mem[wr_ptr] <= '{i_cmd_write, i_cmd_chnl, i_cmd_addr, i_cmd_byte_en, i_cmd_wdata};

  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef AIB_AVMM_CMD_TIMEOUT_EN
  // Counts cycles spent in the current bus phase; restarts whenever a phase is left or entered.
  logic [15:0] tmr;
  assign to_hit = ((state == REQ) || (state == RDWAIT)) && ((tmr + 16'd1) == 16'(TIMEOUT));
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst)
      tmr <= '0;
    else if (!to_hit && (((state == REQ) && i_cfg_avmm_waitreq) ||
                         ((state == RDWAIT) && !i_cfg_avmm_rdatavld)))
      tmr <= tmr + 16'd1;
    else
      tmr <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      state              <= IDLE;
      o_channel_id       <= '0;
      o_cfg_avmm_write   <= 1'b0;
      o_cfg_avmm_read    <= 1'b0;
      o_cfg_avmm_addr    <= '0;
      o_cfg_avmm_byte_en <= '0;
      o_cfg_avmm_wdata   <= '0;
      o_rsp_valid        <= 1'b0;
      o_rsp_rdata        <= '0;
      o_rsp_chnl         <= '0;
      o_rsp_err          <= 2'd0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          o_rsp_chnl  <= head.chnl;
          o_rsp_rdata <= '0;
          if (bad_chnl) begin
            o_rsp_err   <= 2'd2;
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end else begin
            o_channel_id       <= head.chnl;
            o_cfg_avmm_write   <= head.write;
            o_cfg_avmm_read    <= !head.write;
            o_cfg_avmm_addr    <= head.addr;
            o_cfg_avmm_byte_en <= head.be;
            o_cfg_avmm_wdata   <= head.wdata;
            o_rsp_err          <= 2'd0;
            state              <= REQ;
          end
        end
        REQ: if (to_hit) begin
          o_cfg_avmm_write <= 1'b0;
          o_cfg_avmm_read  <= 1'b0;
          o_rsp_err        <= 2'd1;
          o_rsp_valid      <= 1'b1;
          state            <= RSP;
        end else if (!i_cfg_avmm_waitreq) begin
          o_cfg_avmm_write <= 1'b0;
          o_cfg_avmm_read  <= 1'b0;
          if (o_cfg_avmm_write) begin
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end else if (i_cfg_avmm_rdatavld) begin
            o_rsp_rdata <= i_cfg_avmm_rdata;
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: if (to_hit) begin
          o_rsp_err   <= 2'd1;
          o_rsp_valid <= 1'b1;
          state       <= RSP;
        end else if (i_cfg_avmm_rdatavld) begin
          o_rsp_rdata <= i_cfg_avmm_rdata;
          o_rsp_valid <= 1'b1;
          state       <= RSP;
        end
        RSP: if (i_rsp_ready) begin
          o_rsp_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
